fetch_line_buffer: RTL and testbench
====================================

Name: fetch_line_buffer

Overview:
- Parametrised decoupling buffer between the L1I/L0 cacheline source and decode.
- Queues up to LINE_DEPTH fetched cachelines, each tagged with a start PC and a last-valid-instruction index (branch-prediction truncation).
- Emits up to FETCH_WIDTH aligned instructions per cycle from the head line.
- Absorbs L1I latency and decode stalls; drops all contents on a misprediction flush.

Parameters:
- CACHE_LINE_BYTES, 64: bytes per line; power of 2.
- INSTRUCTION_WIDTH, 32: bits per instruction.
- FETCH_WIDTH, 4: instruction slots per output beat; 1..8.
- LINE_DEPTH, 4: lines buffered; power of 2, at least 2.
- PC_WIDTH, 64: address width.
- Derived: IPL = CACHE_LINE_BYTES*8/INSTRUCTION_WIDTH, IDXW = $clog2(IPL), OFFB = $clog2(CACHE_LINE_BYTES).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous reset, active-high
- flush_in  in  1  synchronous squash of all buffered lines
- line_valid_in  in  1  line offered
- line_ready_out  out  1  buffer can accept a line
- line_pc_in  in  PC_WIDTH  first instruction address; bits [1:0] are 0
- line_last_idx_in  in  IDXW  index of the last valid instruction in the line
- line_data_in  in  CACHE_LINE_BYTES*8  line; instruction i occupies bits [i*IW +: IW]
- instr_valid_out  out  1  beat valid
- consumer_ready_in  in  1  decode accepts the beat
- instr_count_out  out  $clog2(FETCH_WIDTH+1)  valid slots, 1..FETCH_WIDTH
- instr_pc_out  out  PC_WIDTH  address of slot 0
- instr_out  out  FETCH_WIDTH*INSTRUCTION_WIDTH  slot k at [k*IW +: IW]
- line_occupancy_out  out  $clog2(LINE_DEPTH+1)  lines stored

Behaviour:
- Reset (async, rst_in=1):
  - head/tail pointers, occupancy, and head offset go to 0.
  - All outputs are 0, including line_ready_out.
  - Reset is allowed mid-operation and discards everything.
- Storage: circular FIFO of entries {base = line_pc_in[PC_WIDTH-1:OFFB], start = line_pc_in[OFFB-1:2], last_idx, data}. Tail and head wrap modulo LINE_DEPTH.
- line_ready_out = !rst_in && occupancy < LINE_DEPTH. There is no pass-through when full, even if the head line retires in the same cycle.
- Push occurs on line_valid_in && line_ready_out && !flush_in.
  - If start > last_idx, the line is accepted but not stored.
  - A stored line becomes visible on the output in the next cycle.
- Head offset register off: loaded with the entry's start when the line becomes head; the FIFO latches start per entry.
- Output is combinational from the head entry:
  - instr_valid_out = occupancy != 0.
  - instr_count_out = min(FETCH_WIDTH, last_idx - off + 1).
  - instr_pc_out = {base, off, 2'b00}.
  - Slot k = instruction off+k for k < count; otherwise 0.
  - A beat never crosses a line boundary.
- Pop beat occurs on instr_valid_out && consumer_ready_in.
  - off += count.
  - If off+count > last_idx, the head retires: head++ and off loads the next entry's start.
- Simultaneous push and retire leaves occupancy unchanged. Occupancy is always head-to-tail distance; it never wraps.
- flush_in takes priority over push and pop in the same cycle.
  - Next cycle: occupancy 0, instr_valid_out 0, pointers 0.
  - A line offered during the flush cycle is dropped.
  - line_ready_out is still driven from the current occupancy, so the producer sees a completed handshake for the dropped line.
- Outputs are stable while instr_valid_out && !consumer_ready_in.

Decomposition:
- frontend_pkg holds:
  - IPL and IDXW constants.
  - typedef fetch_line_entry_t {base, start, last_idx, data}.
- One sub-module, fetch_slot_select (combinational): takes data, off, and last_idx; produces instr_out and instr_count_out.
- fetch_line_buffer owns the FIFO, pointers, and offset.

Test Plan:
All scenarios use default parameters; consumer_ready_in=1 unless stated.
- Basic drain: push pc 0x1000, last_idx 15 → 4 beats, each count 4, pcs 0x1000/0x1010/0x1020/0x1030 → occupancy returns to 0 after the 4th beat.
- Misaligned start: push pc 0x2038, last_idx 15 → 1 beat, count 2, pc 0x2038, slots 2-3 = 0.
- Truncation: push pc 0x3000, last_idx 5 → beats with count 4 then count 2; second beat pc 0x3010; retires after the second beat.
- Backpressure/full:
  - With consumer_ready_in=0, push 4 lines → line_ready_out=0 after the 4th; a 5th offer is held.
  - Raise ready; after the head's last beat → line_ready_out=1 on the next cycle.
  - The 5th line is emitted last, in order.
- Flush: with 3 lines queued, assert flush_in with line_valid_in=1 in the same cycle → next cycle occupancy 0, instr_valid_out 0; the offered line is never emitted.
- Dropped line, then reset mid-drain:
  - Push pc 0x4030, last_idx 3 → accepted, occupancy stays 0.
  - Queue 2 lines, assert rst_in mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/frontend_pkg.sv
// Shared fetch-frontend types and constants.
// Defaults for the line buffer plus the stored line entry layout.
package frontend_pkg;

  localparam int DEF_LINE_BYTES = 64;
  localparam int DEF_IW         = 32;
  localparam int DEF_FW         = 4;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_PCW        = 64;

  localparam int LINE_BITS = DEF_LINE_BYTES * 8;
  localparam int IPL       = LINE_BITS / DEF_IW;
  localparam int IDXW      = $clog2(IPL);
  localparam int OFFB      = $clog2(DEF_LINE_BYTES);
  localparam int CNTW      = $clog2(DEF_FW + 1);

  typedef struct packed {
    logic [DEF_PCW-OFFB-1:0] base;
    logic [OFFB-3:0]         start;
    logic [IDXW-1:0]         last_idx;
    logic [LINE_BITS-1:0]    data;
  } fetch_line_entry_t;

endpackage

// File: rtl/fetch_line_buffer_if.sv
// Line-in / instruction-beat-out bundle of the fetch line buffer.
// slave: buffer side. master: producer + decode side.
interface fetch_line_buffer_if;
  import frontend_pkg::*;

  logic                       line_valid_in;
  logic                       line_ready_out;
  logic [DEF_PCW-1:0]         line_pc_in;
  logic [IDXW-1:0]            line_last_idx_in;
  logic [LINE_BITS-1:0]       line_data_in;
  logic                       instr_valid_out;
  logic                       consumer_ready_in;
  logic [CNTW-1:0]            instr_count_out;
  logic [DEF_PCW-1:0]         instr_pc_out;
  logic [DEF_FW*DEF_IW-1:0]   instr_out;

  modport slave (
    input  line_valid_in, line_pc_in,
    input  line_last_idx_in, line_data_in,
    input  consumer_ready_in,
    output line_ready_out, instr_valid_out,
    output instr_count_out, instr_pc_out,
    output instr_out
  );

  modport master (
    output line_valid_in, line_pc_in,
    output line_last_idx_in, line_data_in,
    output consumer_ready_in,
    input  line_ready_out, instr_valid_out,
    input  instr_count_out, instr_pc_out,
    input  instr_out
  );

endinterface

// File: rtl/fetch_slot_select.sv
// Picks up to FETCH_WIDTH instructions from a line at offset off_i.
// data_i/off_i/last_idx_i in; instr_o slots and count_o out.
module fetch_slot_select
  import frontend_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_IW,
  parameter int FETCH_WIDTH       = DEF_FW,
  localparam int CW = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [LINE_BITS-1:0] data_i,
  input  logic [IDXW-1:0]      off_i,
  input  logic [IDXW-1:0]      last_idx_i,
  output logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0] instr_o,
  output logic [CW-1:0]        count_o
);

  localparam int RW = IDXW + 1;

  logic [RW-1:0]   rem;
  logic [CW-1:0]   cnt;
  logic [IDXW-1:0] idx;

  always_comb begin
    rem = {1'b0, last_idx_i} - {1'b0, off_i} + RW'(1);
    cnt = (rem > RW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH)
                                  : CW'(rem);
    instr_o = '0;
    idx = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k < int'(cnt)) begin
        idx = off_i + IDXW'(k);
        instr_o[k*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] =
          data_i[idx*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
      end
    end
  end

  assign count_o = cnt;

endmodule

// File: rtl/fetch_line_buffer.sv
// Cacheline FIFO between L1I and decode, emitting aligned beats.
// Ports: clk_in, rst_in, flush_in, bus (slave), line_occupancy_out.
module fetch_line_buffer
  import frontend_pkg::*;
#(
  parameter int CACHE_LINE_BYTES  = DEF_LINE_BYTES,
  parameter int INSTRUCTION_WIDTH = DEF_IW,
  parameter int FETCH_WIDTH       = DEF_FW,
  parameter int LINE_DEPTH        = DEF_DEPTH,
  parameter int PC_WIDTH          = DEF_PCW
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic flush_in,
  fetch_line_buffer_if.slave bus,
  output logic [$clog2(LINE_DEPTH+1)-1:0] line_occupancy_out
);

  localparam int OB   = $clog2(CACHE_LINE_BYTES);
  localparam int PTRW = $clog2(LINE_DEPTH);
  localparam int OCCW = $clog2(LINE_DEPTH + 1);
  localparam int CW   = $clog2(FETCH_WIDTH + 1);

  fetch_line_entry_t mem_q [LINE_DEPTH];
  fetch_line_entry_t in_e;

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, head_nx;
  logic [OCCW-1:0] occ_q, occ_d;
  logic [IDXW-1:0] off_q, off_d;
  logic [IDXW:0]   sum;
  logic [CW-1:0]   cnt;
  logic [FETCH_WIDTH*INSTRUCTION_WIDTH-1:0] slots;
  logic valid, ready, push, store, pop, retire;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^bus.line_pc_in[1:0];

  assign in_e.base     = bus.line_pc_in[PC_WIDTH-1:OB];
  assign in_e.start    = bus.line_pc_in[OB-1:2];
  assign in_e.last_idx = bus.line_last_idx_in;
  assign in_e.data     = bus.line_data_in;

  assign head_nx = head_q + PTRW'(1);
  assign valid   = occ_q != '0;
  assign ready   = !rst_in && (occ_q < OCCW'(LINE_DEPTH));
  assign push    = bus.line_valid_in && ready && !flush_in;
  // Lines whose start lies past last_idx hold nothing to issue.
  assign store   = push && (in_e.start <= in_e.last_idx);
  assign pop     = valid && bus.consumer_ready_in && !flush_in;
  assign sum     = {1'b0, off_q} + (IDXW+1)'(cnt);
  assign retire  = pop && (sum > {1'b0, mem_q[head_q].last_idx});

  fetch_slot_select #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .FETCH_WIDTH       (FETCH_WIDTH)
  ) u_sel (
    .data_i     (mem_q[head_q].data),
    .off_i      (off_q),
    .last_idx_i (mem_q[head_q].last_idx),
    .instr_o    (slots),
    .count_o    (cnt)
  );

  assign bus.line_ready_out  = ready;
  assign bus.instr_valid_out = valid;
  assign bus.instr_count_out = valid ? cnt : '0;
  assign bus.instr_pc_out    =
    valid ? {mem_q[head_q].base, off_q, 2'b00} : '0;
  assign bus.instr_out       = valid ? slots : '0;
  assign line_occupancy_out  = occ_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    off_d  = off_q;
    if (flush_in) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      off_d  = '0;
    end else begin
      if (store) tail_d = tail_q + PTRW'(1);
      if (retire) head_d = head_nx;
      occ_d = occ_q + OCCW'(store) - OCCW'(retire);
      // off tracks the head line; reload whenever a new line
      // becomes head (queued successor or the one arriving now).
      if (retire) begin
        if (occ_q > OCCW'(1)) off_d = mem_q[head_nx].start;
        else if (store)       off_d = in_e.start;
        else                  off_d = '0;
      end else if (pop) begin
        off_d = sum[IDXW-1:0];
      end else if (store && occ_q == '0) begin
        off_d = in_e.start;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      off_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      off_q  <= off_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (store) mem_q[tail_q] <= in_e;
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Randomised + directed bench for fetch_line_buffer.
// Reference: per-line list of expected beats held in a queue.
module tb_fetch_line_buffer;

  typedef struct {
    logic [63:0]  pc;
    int           cnt;
    logic [127:0] ins;
    bit           last;
  } beat_t;

  bit   clk = 1'b0;
  logic rst;
  logic flush;
  logic [2:0] occ;

  beat_t q[$];
  int occ_m = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_line_buffer_if bus ();

  fetch_line_buffer u_dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .flush_in           (flush),
    .bus                (bus.slave),
    .line_occupancy_out (occ)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [63:0] pc,
                            input logic [3:0] li,
                            input logic [511:0] d);
    int s;
    int l;
    s = int'(pc[5:2]);
    l = int'(li);
    if (s > l) return;
    occ_m++;
    for (int i = s; i <= l; i += 4) begin
      beat_t b;
      b.cnt = (l - i + 1 > 4) ? 4 : l - i + 1;
      b.pc = {pc[63:6], 6'b0} + 64'(i * 4);
      b.ins = '0;
      for (int k = 0; k < b.cnt; k++)
        b.ins[k*32 +: 32] = d[(i+k)*32 +: 32];
      b.last = (i + b.cnt > l);
      q.push_back(b);
    end
  endtask

  task automatic check_out();
    beat_t e;
    bit ev;
    ev = q.size() != 0;
    e.pc = '0;
    e.cnt = 0;
    e.ins = '0;
    if (ev) e = q[0];
    chk("valid", 128'(bus.instr_valid_out), 128'(ev));
    chk("count", 128'(bus.instr_count_out), 128'(e.cnt));
    chk("pc", 128'(bus.instr_pc_out), 128'(e.pc));
    chk("instr", bus.instr_out, e.ins);
    chk("occ", 128'(occ), 128'(occ_m));
    chk("ready", 128'(bus.line_ready_out), 128'(occ_m < 4));
  endtask

  task automatic chk_zero();
    chk("rst_valid", 128'(bus.instr_valid_out), 128'(0));
    chk("rst_count", 128'(bus.instr_count_out), 128'(0));
    chk("rst_pc", 128'(bus.instr_pc_out), 128'(0));
    chk("rst_instr", bus.instr_out, 128'(0));
    chk("rst_occ", 128'(occ), 128'(0));
    chk("rst_ready", 128'(bus.line_ready_out), 128'(0));
  endtask

  // Called at a negedge; drives one cycle, advances the model,
  // then checks the outputs at the following negedge.
  task automatic step(input bit v, input logic [63:0] pc,
                      input logic [3:0] li,
                      input logic [511:0] d,
                      input bit rdy, input bit fl,
                      output bit took);
    bit rdy_m;
    bit popm;
    bit pushm;
    bus.line_valid_in     = v;
    bus.line_pc_in        = pc;
    bus.line_last_idx_in  = li;
    bus.line_data_in      = d;
    bus.consumer_ready_in = rdy;
    flush                 = fl;
    rdy_m = occ_m < 4;
    pushm = v && rdy_m && !fl;
    popm  = q.size() != 0 && rdy && !fl;
    took  = v && rdy_m;
    if (fl) begin
      q.delete();
      occ_m = 0;
    end else begin
      if (popm) begin
        if (q[0].last) occ_m--;
        void'(q.pop_front());
      end
      if (pushm) model_push(pc, li, d);
    end
    @(negedge clk);
    check_out();
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle(input bit rdy, input int n);
    bit t;
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, rdy, 0, t);
  endtask

  task automatic push_wait(input logic [63:0] pc,
                           input logic [3:0] li,
                           input logic [511:0] d,
                           input bit rdy);
    bit t;
    int n;
    n = 0;
    t = 0;
    while (!t && n < 64) begin
      step(1, pc, li, d, rdy, 0, t);
      n++;
    end
    if (!t) chk("push_timeout", 128'(t), 128'(1));
  endtask

  initial begin
    bit t;
    logic [63:0] pc;
    rst = 1'b0;
    flush = 1'b0;
    bus.line_valid_in = 1'b0;
    bus.line_pc_in = '0;
    bus.line_last_idx_in = '0;
    bus.line_data_in = '0;
    bus.consumer_ready_in = 1'b1;
    #1 rst = 1'b1;
    #1 chk_zero();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_out();

    push_wait(64'h1000, 4'd15, rand_data(), 1);
    idle(1, 5);
    push_wait(64'h2038, 4'd15, rand_data(), 1);
    idle(1, 2);
    push_wait(64'h3000, 4'd5, rand_data(), 1);
    idle(1, 3);

    for (int i = 0; i < 4; i++)
      push_wait(64'h5000 + 64'(i * 64), 4'($urandom_range(0, 15)),
                rand_data(), 0);
    step(1, 64'h6004, 4'd9, rand_data(), 0, 0, t);
    step(1, 64'h6004, 4'd9, rand_data(), 0, 0, t);
    push_wait(64'h6004, 4'd9, rand_data(), 1);
    idle(1, 20);

    for (int i = 0; i < 3; i++)
      push_wait(64'h7000 + 64'(i * 64), 4'd15, rand_data(), 0);
    step(1, 64'h8000, 4'd15, rand_data(), 1, 1, t);
    idle(1, 3);

    push_wait(64'h4030, 4'd3, rand_data(), 1);
    idle(1, 1);

    push_wait(64'h9000, 4'd15, rand_data(), 0);
    push_wait(64'h9040, 4'd7, rand_data(), 0);
    bus.line_valid_in = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero();
    q.delete();
    occ_m = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 check_out();

    for (int i = 0; i < 600; i++) begin
      pc = {$urandom, $urandom};
      pc[1:0] = 2'b00;
      step(($urandom % 3) != 0, pc, 4'($urandom_range(0, 15)),
           rand_data(), ($urandom % 4) != 0,
           ($urandom % 40) == 0, t);
    end
    idle(1, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
